// File: rtl/pc_seq_ysyx_if.sv
// IFU request/response bundle between the sequencer and instruction memory.
// master: sequencer side, slave: IFU side.
interface pc_seq_ysyx_if;
   logic        ifu_req_valid;
   logic [31:0] ifu_req_addr;
   logic        ifu_req_ready;
   logic        ifu_resp_valid;
   logic [31:0] ifu_resp_inst;
   logic        ifu_resp_err;

   modport master (
      output ifu_req_valid,
      output ifu_req_addr,
      input  ifu_req_ready,
      input  ifu_resp_valid,
      input  ifu_resp_inst,
      input  ifu_resp_err
   );

   modport slave (
      input  ifu_req_valid,
      input  ifu_req_addr,
      output ifu_req_ready,
      output ifu_resp_valid,
      output ifu_resp_inst,
      output ifu_resp_err
   );
endinterface

// File: rtl/pc_seq_ysyx.sv
// PC sequencer: fetch/wait/exec control loop, sole writer of the PC.
// Define PC_SEQ_PERF_EN to build the cycle / retired-instruction counters.
module pc_seq_ysyx #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   pc_seq_ysyx_if.master     ifu,
   output logic [31:0]       pc,
   output logic [31:0]       inst,
   output logic              exu_start,
   input  logic              exu_done,
   input  logic [31:0]       npc,
   input  logic              trap,
   input  logic [31:0]       trap_pc,
   input  logic              halt,
   output logic              commit,
   output logic              fault,
   output logic              halted,
   output logic [31:0]       cyc_cnt,
   output logic [31:0]       inst_cnt
);

   typedef enum logic [2:0] {
      ST_RESET,
      ST_FETCH,
      ST_WAIT,
      ST_EXEC,
      ST_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        started_q;
   logic        req_valid;
   logic        start;
   logic        retire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RESET;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         started_q <= (state_q == ST_EXEC);
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      req_valid = 1'b0;
      start     = 1'b0;
      commit    = 1'b0;
      fault     = 1'b0;
      retire    = 1'b0;
      halted    = 1'b0;
      unique case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            req_valid = 1'b1;
            if (ifu.ifu_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (ifu.ifu_resp_valid) begin
               if (ifu.ifu_resp_err) begin
                  pc_d    = trap_pc;
                  commit  = 1'b1;
                  fault   = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  inst_d  = ifu.ifu_resp_inst;
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            start = !started_q;
            // halt beats trap beats misaligned npc beats normal retire
            if (exu_done) begin
               if (halt) begin
                  state_d = ST_HALT;
               end else if (trap) begin
                  pc_d    = trap_pc;
                  commit  = 1'b1;
                  state_d = ST_FETCH;
               end else if (npc[1:0] != 2'b00) begin
                  pc_d    = trap_pc;
                  commit  = 1'b1;
                  fault   = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  pc_d    = npc;
                  commit  = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_HALT: halted = 1'b1;
         default: state_d = ST_RESET;
      endcase
   end

   assign pc                = pc_q;
   assign inst              = inst_q;
   assign exu_start         = start;
   assign ifu.ifu_req_valid = req_valid;
   assign ifu.ifu_req_addr  = pc_q;

`ifdef PC_SEQ_PERF_EN
   logic [31:0] cyc_q;
   logic [31:0] icnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         icnt_q <= '0;
      end else begin
         if (state_q != ST_RESET && state_q != ST_HALT)
            cyc_q <= cyc_q + 32'd1;
         if (retire)
            icnt_q <= icnt_q + 32'd1;
      end
   end

   assign cyc_cnt  = cyc_q;
   assign inst_cnt = icnt_q;
`else
   logic unused_retire;
   assign unused_retire = retire;
   assign cyc_cnt       = '0;
   assign inst_cnt      = '0;
`endif

endmodule

// File: tb/tb_pc_seq_ysyx.sv
// Bench for pc_seq_ysyx: directed vector table, reset/halt sequences,
// and randomized instructions against an instruction-level model.
module tb_pc_seq_ysyx;
   localparam logic [31:0] RPC = 32'h8000_0000;
`ifdef PC_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc, inst, npc, trap_pc, cyc_cnt, inst_cnt;
   logic        exu_start, exu_done, trap, halt;
   logic        commit, fault, halted;

   always #5 clk = ~clk;

   pc_seq_ysyx_if ifu ();

   pc_seq_ysyx #(.RESET_PC(RPC)) dut (
      .clk      (clk),
      .rst      (rst),
      .ifu      (ifu.master),
      .pc       (pc),
      .inst     (inst),
      .exu_start(exu_start),
      .exu_done (exu_done),
      .npc      (npc),
      .trap     (trap),
      .trap_pc  (trap_pc),
      .halt     (halt),
      .commit   (commit),
      .fault    (fault),
      .halted   (halted),
      .cyc_cnt  (cyc_cnt),
      .inst_cnt (inst_cnt)
   );

   typedef struct {
      int          rd;
      int          rsp;
      int          dd;
      bit          err;
      bit          trp;
      bit          hlt;
      logic [31:0] nx;
      logic [31:0] tpc;
      logic [31:0] exp_pc;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_pc, m_inst, m_cyc, m_icnt;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      ifu.ifu_req_ready  = 1'b0;
      ifu.ifu_resp_valid = 1'b0;
      ifu.ifu_resp_err   = 1'b0;
      ifu.ifu_resp_inst  = '0;
      exu_done = 1'b0;
      trap     = 1'b0;
      halt     = 1'b0;
      npc      = '0;
   endtask

   task automatic junk();
      ifu.ifu_req_ready  = 1'($urandom_range(0, 1));
      ifu.ifu_resp_valid = 1'($urandom_range(0, 1));
      ifu.ifu_resp_err   = 1'($urandom_range(0, 1));
      ifu.ifu_resp_inst  = $urandom;
      exu_done = 1'($urandom_range(0, 1));
      trap     = 1'($urandom_range(0, 1));
      halt     = 1'($urandom_range(0, 1));
      npc      = $urandom;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_pc"}, pc, m_pc);
      chk({tag, "_inst"}, inst, m_inst);
      chk({tag, "_cyc"}, cyc_cnt, PERF ? m_cyc : 32'd0);
      chk({tag, "_icnt"}, inst_cnt, PERF ? m_icnt : 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle();
      @(posedge clk);
      #1;
      m_pc = RPC; m_inst = '0; m_cyc = '0; m_icnt = '0;
      check_regs("rst");
      chk("rst_req_valid", ifu.ifu_req_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_commit", commit, 0);
      chk("rst_fault", fault, 0);
      chk("rst_start", exu_start, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_state_req", ifu.ifu_req_valid, 0);
   endtask

   task automatic run_inst(input int rd, input int rsp, input int dd,
                           input bit err, input bit trp, input bit hlt,
                           input logic [31:0] nx, input logic [31:0] tpc);
      logic [31:0] iw;
      bit          last;
      iw = $urandom;
      trap_pc = tpc;
      for (int i = 0; i <= rd; i++) begin
         @(negedge clk);
         junk();
         ifu.ifu_req_ready = (i == rd);
         #1;
         chk("fetch_valid", ifu.ifu_req_valid, 1);
         chk("fetch_addr", ifu.ifu_req_addr, m_pc);
         chk("fetch_commit", commit, 0);
         chk("fetch_start", exu_start, 0);
         m_cyc++;
      end
      for (int i = 0; i <= rsp; i++) begin
         @(negedge clk);
         junk();
         last = (i == rsp);
         ifu.ifu_resp_valid = last;
         if (last) ifu.ifu_resp_err = err;
         ifu.ifu_resp_inst = iw;
         #1;
         chk("wait_valid", ifu.ifu_req_valid, 0);
         chk("wait_commit", commit, last && err);
         chk("wait_fault", fault, last && err);
         chk("wait_start", exu_start, 0);
         m_cyc++;
      end
      if (err) begin
         m_pc = tpc;
      end else begin
         m_inst = iw;
         for (int i = 0; i <= dd; i++) begin
            @(negedge clk);
            junk();
            last = (i == dd);
            exu_done = last;
            if (last) begin
               trap = trp;
               halt = hlt;
               npc  = nx;
            end
            #1;
            chk("exec_start", exu_start, i == 0);
            chk("exec_inst", inst, m_inst);
            chk("exec_commit", commit, last && !hlt);
            chk("exec_fault", fault,
                last && !hlt && !trp && (nx[1:0] != 2'b00));
            chk("exec_halted", halted, 0);
            m_cyc++;
         end
         if (hlt) begin
         end else if (trp || nx[1:0] != 2'b00) begin
            m_pc = tpc;
         end else begin
            m_pc = nx;
            m_icnt++;
         end
      end
      @(posedge clk);
      #1;
      check_regs("post");
      chk("post_halted", halted, hlt && !err);
      chk("post_req_valid", ifu.ifu_req_valid, !(hlt && !err));
   endtask

   task automatic halt_hold();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         junk();
         exu_done = 1'b1;
         ifu.ifu_req_ready = 1'b1;
         #1;
         chk("halt_halted", halted, 1);
         chk("halt_req_valid", ifu.ifu_req_valid, 0);
         chk("halt_commit", commit, 0);
         chk("halt_fault", fault, 0);
         chk("halt_start", exu_start, 0);
      end
      check_regs("halt");
   endtask

   vec_t vt[6];

   initial begin
      logic [31:0] r, nx, tpc;
      int          sel;
      vt[0] = '{0, 0, 0, 0, 0, 0, 32'h8000_0004, 32'h8000_1000, 32'h8000_0004};
      vt[1] = '{5, 0, 0, 0, 0, 0, 32'h8000_0008, 32'h8000_1000, 32'h8000_0008};
      vt[2] = '{0, 0, 0, 1, 0, 0, 32'h8000_000c, 32'h8000_1000, 32'h8000_1000};
      vt[3] = '{0, 1, 0, 0, 0, 0, 32'h8000_1006, 32'h8000_2000, 32'h8000_2000};
      vt[4] = '{1, 0, 2, 0, 1, 0, 32'h8000_2004, 32'h8000_3000, 32'h8000_3000};
      vt[5] = '{0, 2, 3, 0, 0, 0, 32'h8000_3010, 32'h8000_4000, 32'h8000_3010};
      idle();
      trap_pc = '0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         run_inst(vt[i].rd, vt[i].rsp, vt[i].dd, vt[i].err,
                  vt[i].trp, vt[i].hlt, vt[i].nx, vt[i].tpc);
         chk("vec_pc", pc, vt[i].exp_pc);
      end

      // reset while a response is pending in WAIT
      @(negedge clk);
      idle();
      ifu.ifu_req_ready = 1'b1;
      @(negedge clk);
      idle();
      rst = 1'b1;
      ifu.ifu_resp_valid = 1'b1;
      ifu.ifu_resp_inst  = 32'hdead_beef;
      @(posedge clk);
      #1;
      chk("midwait_pc", pc, RPC);
      chk("midwait_inst", inst, 0);
      chk("midwait_req", ifu.ifu_req_valid, 0);
      chk("midwait_cyc", cyc_cnt, 0);
      chk("midwait_icnt", inst_cnt, 0);
      do_reset();
      for (int i = 0; i < 10; i++)
         run_inst(0, 0, 0, 0, 0, 0, m_pc + 32'd4, 32'h8000_1000);
      chk("perf10_icnt", inst_cnt, PERF ? 32'd10 : 32'd0);
      chk("perf10_cyc", cyc_cnt, PERF ? 32'd30 : 32'd0);
      chk("perf10_pc", pc, RPC + 32'd40);

      // halt wins over trap
      do_reset();
      run_inst(0, 0, 1, 0, 1, 1, 32'h8000_0004, 32'h8000_1000);
      chk("halt_pc", pc, RPC);
      halt_hold();
      do_reset();
      run_inst(0, 0, 0, 0, 1, 0, 32'h8000_0004, 32'h8000_5000);
      chk("trap_pc", pc, 32'h8000_5000);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 7);
         r = $urandom;
         if (sel < 4) nx = m_pc + 32'd4;
         else if (sel < 6) nx = {r[31:2], 2'b00};
         else nx = {r[31:2], 2'b00} | 32'($urandom_range(1, 3));
         r = $urandom;
         tpc = {r[31:4], 4'h0};
         run_inst($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, 1'b0, nx, tpc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
